// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, default parameters and FSM state type for the ALU sweep driver
package alu_pkg;
    localparam int N_DEF       = 4;
    localparam int CTRL_W      = 3;
    localparam int NUM_OPS_DEF = 7;
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/alu_result_regfile.sv
// alu_result_regfile: NUM_OPS x (N+2) result store, sync clear, one write port, comb read (out of range reads 0)
// ports: clk, rst_n (sync, active-low), clr, we, waddr, wdata, raddr, rdata
module alu_result_regfile
    import alu_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [CTRL_W-1:0] waddr,
    input  logic [N+1:0]      wdata,
    input  logic [CTRL_W-1:0] raddr,
    output logic [N+1:0]      rdata
);
    logic [N+1:0] mem [NUM_OPS];

    always_ff @(posedge clk)
        if (!rst_n || clr)
            for (int i = 0; i < NUM_OPS; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;

    assign rdata = (32'(raddr) < NUM_OPS) ? mem[raddr] : '0;
endmodule

// File: rtl/alu_sweep_driver.sv
// alu_sweep_driver: drives every opcode 0..NUM_OPS-1 into an external ALU and records each response
// ports: clk, rst_n (sync, active-low), start, a_in/b_in -> alu_a/alu_b/alu_control to ALU;
//        alu_out/alu_overflow/alu_zero from ALU; busy, done; rd_addr -> rd_data; ovf_count, zero_count
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int SETTLE  = 1,
    localparam int CW     = $clog2(NUM_OPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      a_in,
    input  logic [N-1:0]      b_in,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [N-1:0]      alu_out,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    input  logic [CTRL_W-1:0] rd_addr,
    output logic [N+1:0]      rd_data,
    output logic [CW-1:0]     ovf_count,
    output logic [CW-1:0]     zero_count
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    state_t        state, state_nx;
    logic [SW-1:0] settle_cnt;
    logic          accept, capture, last;

    assign accept  = state == IDLE && start;
    assign capture = state == CAPTURE;
    assign last    = alu_control == CTRL_W'(NUM_OPS - 1);

    always_comb begin
        state_nx = state;
        busy     = state == DRIVE || state == CAPTURE;
        done     = state == DONE;
        unique case (state)
            IDLE:    state_nx = start ? DRIVE : IDLE;
            DRIVE:   state_nx = settle_cnt == SW'(SETTLE - 1) ? CAPTURE : DRIVE;
            CAPTURE: state_nx = last ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            ovf_count   <= '0;
            zero_count  <= '0;
        end else begin
            state      <= state_nx;
            // counts cycles spent in DRIVE; restarts on every entry
            settle_cnt <= state == DRIVE ? settle_cnt + SW'(1) : '0;
            if (accept) begin
                alu_a       <= a_in;
                alu_b       <= b_in;
                alu_control <= '0;
                ovf_count   <= '0;
                zero_count  <= '0;
            end
            if (capture) begin
                ovf_count  <= ovf_count + CW'(alu_overflow);
                zero_count <= zero_count + CW'(alu_zero);
                if (!last) alu_control <= alu_control + CTRL_W'(1);
            end
        end

    alu_result_regfile #(.N(N), .NUM_OPS(NUM_OPS)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .we    (capture),
        .waddr (alu_control),
        .wdata ({alu_overflow, alu_zero, alu_out}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule
